minhash_signature_gen: RTL

- Upstream feeder for the sorter stage. Accepts a framed stream of shingle words over a valid/ready handshake.
- Hashes each word through a 2-stage pipeline: seed XOR, then affine multiply, then xor-shift fold.
- Emits a valid/signature/index stream that connects directly to the sorter's valid_in/signature_in/index_in.
- Assigns sequential indices per frame, pulses frame_done when the last signature has left the pipeline, and flags index overflow.

---
 rtl/minhash_signature_gen.sv | 117 +++++++++++
 1 files changed

// File: rtl/minhash_signature_gen.sv
// MinHash signature generator: framed shingle words in, seeded affine hash with xor-shift fold out,
// two-stage pipeline with per-frame indices, frame_done pulse and sticky index-overflow flag.
module minhash_signature_gen #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned SIGNATURE_WIDTH = 32,
    parameter int unsigned INDEX_WIDTH     = 10,
    parameter logic [SIGNATURE_WIDTH-1:0] HASH_A = 32'h9E3779B1,
    parameter logic [SIGNATURE_WIDTH-1:0] HASH_B = 32'h7F4A7C15
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [DATA_WIDTH-1:0]      seed_in,
    input  logic                       data_valid,
    input  logic [DATA_WIDTH-1:0]      data_in,
    input  logic                       data_last,
    output logic                       data_ready,
    output logic                       valid_out,
    output logic [SIGNATURE_WIDTH-1:0] signature_out,
    output logic [INDEX_WIDTH-1:0]     index_out,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                              state;
    logic [DATA_WIDTH-1:0]               seed;
    logic [INDEX_WIDTH-1:0]              idx_cnt;
    logic                                s1_valid;
    logic [DATA_WIDTH-1:0]               s1_x;
    logic [INDEX_WIDTH-1:0]              s1_idx;
    logic                                accept;
    logic                                last_slot;
    logic [DATA_WIDTH+SIGNATURE_WIDTH-1:0] x_ext;
    logic [SIGNATURE_WIDTH-1:0]          x_fit;
    logic [SIGNATURE_WIDTH-1:0]          p;
    logic [SIGNATURE_WIDTH-1:0]          sig_next;

    assign data_ready = (state == RUN);
    assign busy       = (state != IDLE);
    assign accept     = data_valid & data_ready;
    assign last_slot  = (idx_cnt == '1);

    // Zero-extend then truncate so x fits SIGNATURE_WIDTH whichever width is larger.
    always_comb begin
        x_ext    = {{SIGNATURE_WIDTH{1'b0}}, s1_x};
        x_fit    = x_ext[SIGNATURE_WIDTH-1:0];
        p        = x_fit * HASH_A + HASH_B;
        sig_next = p ^ (p >> (SIGNATURE_WIDTH / 2));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            seed          <= '0;
            idx_cnt       <= '0;
            s1_valid      <= 1'b0;
            s1_x          <= '0;
            s1_idx        <= '0;
            valid_out     <= 1'b0;
            signature_out <= '0;
            index_out     <= '0;
            frame_done    <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            s1_valid   <= accept;
            valid_out  <= s1_valid;

            if (accept) begin
                s1_x    <= data_in ^ seed;
                s1_idx  <= idx_cnt;
                idx_cnt <= idx_cnt + 1'b1;
            end

            if (s1_valid) begin
                signature_out <= sig_next;
                index_out     <= s1_idx;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        seed     <= seed_in;
                        idx_cnt  <= '0;
                        overflow <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (accept && (data_last || last_slot)) begin
                        state <= DRAIN;
                        if (!data_last) begin
                            overflow <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // No accepts in DRAIN, so an empty stage 1 means both valids are 0
                    // after this edge: the final valid_out is leaving right now.
                    if (!s1_valid) begin
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
